// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the on-chip RAM.
// Signal names match the original flat port list so existing connections map one-to-one.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_address;
    logic [DATA_W/8-1:0] m0_byteenable;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic                m0_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;

    logic [ADDR_W-1:0]   m1_address;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic                m1_waitrequest;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic                oor_error;

    // Arbiter view
    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken, oor_error,
        input  mem_readdata
    );

    // Environment view: both masters plus the RAM
    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken, oor_error,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Grants are combinational; only the read-return tracking, last grant and error flag are registered.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5120
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  bus
);
    localparam int               BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic              req0, req1, grant0, grant1, any_grant;
    logic              wr_sel, rd_sel, in_range;
    logic [ADDR_W-1:0] addr_sel;
    logic [BE_W-1:0]   be_sel;
    logic [DATA_W-1:0] wd_sel, rdata;

    logic last_grant_q, last_grant_d;
    logic rv_pend_q, rv_pend_d;
    logic rv_owner_q, rv_owner_d;
    logic rv_oor_q, rv_oor_d;
    logic oor_q, oor_d;

    always_comb begin
        req0      = bus.m0_read | bus.m0_write;
        req1      = bus.m1_read | bus.m1_write;
        // Reset gating keeps both masters stalled while reset_n is low
        grant0    = reset_n & req0 & (~req1 | last_grant_q);
        grant1    = reset_n & req1 & (~req0 | ~last_grant_q);
        any_grant = grant0 | grant1;

        addr_sel  = grant1 ? bus.m1_address    : bus.m0_address;
        be_sel    = grant1 ? bus.m1_byteenable : bus.m0_byteenable;
        wd_sel    = grant1 ? bus.m1_writedata  : bus.m0_writedata;
        wr_sel    = grant1 ? bus.m1_write      : bus.m0_write;
        rd_sel    = grant1 ? (bus.m1_read & ~bus.m1_write) : (bus.m0_read & ~bus.m0_write);
        in_range  = {1'b0, addr_sel} < DEPTH_W;

        last_grant_d = any_grant ? grant1 : last_grant_q;
        rv_pend_d    = any_grant & rd_sel;
        rv_owner_d   = grant1;
        rv_oor_d     = ~in_range;
        oor_d        = oor_q | (any_grant & ~in_range);

        rdata = rv_oor_q ? '0 : bus.mem_readdata;
    end

    always_comb begin
        bus.m0_waitrequest   = ~grant0;
        bus.m1_waitrequest   = ~grant1;
        bus.m0_readdatavalid = rv_pend_q & ~rv_owner_q;
        bus.m1_readdatavalid = rv_pend_q & rv_owner_q;
        bus.m0_readdata      = (rv_pend_q & ~rv_owner_q) ? rdata : '0;
        bus.m1_readdata      = (rv_pend_q & rv_owner_q) ? rdata : '0;

        bus.mem_address    = addr_sel;
        bus.mem_byteenable = wr_sel ? be_sel : '1;
        bus.mem_writedata  = wd_sel;
        bus.mem_chipselect = any_grant;
        bus.mem_write      = any_grant & wr_sel & in_range;
        bus.mem_clken      = 1'b1;
        bus.oor_error      = oor_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rv_pend_q    <= 1'b0;
            rv_owner_q   <= 1'b0;
            rv_oor_q     <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rv_pend_q    <= rv_pend_d;
            rv_owner_q   <= rv_owner_d;
            rv_oor_q     <= rv_oor_d;
            oor_q        <= oor_d;
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM model plus a transaction-level reference
// (round-robin rule, word store, expected read return) checked every cycle.
module tb_onchip_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus();
    onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .DEPTH(5120)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // On-chip RAM: registered read, byte-lane writes
    logic [31:0] ram [0:8191];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            ram_q <= ram[bus.mem_address];
        end
    end
    assign bus.mem_readdata = ram_q;

    typedef struct packed {
        logic        wr0, wr1, v0, v1;
        logic [31:0] d0, d1;
        logic        cs, mw, oor;
    } snap_t;

    snap_t ex, ob;
    int tests = 0;
    int fails = 0;

    // Reference state
    logic [31:0] mmem [int];
    logic        lg = 1'b1;
    logic        pv0 = 1'b0, pv1 = 1'b0, moor = 1'b0;
    logic [31:0] pd = '0;

    task automatic model_reset();
        lg = 1'b1; pv0 = 1'b0; pv1 = 1'b0; moor = 1'b0;
    endtask

    task automatic zero_inputs();
        bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_writedata = '0;
        bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
    endtask

    // One bus cycle: drive at negedge, sample before posedge, then advance the model
    task automatic cycle(input logic r0, w0, input logic [12:0] a0, input logic [3:0] be0, input logic [31:0] d0,
                         input logic r1, w1, input logic [12:0] a1, input logic [3:0] be1, input logic [31:0] d1);
        logic q0, q1, g0, g1, gw, grd;
        logic [12:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gd, word;
        @(negedge clk);
        bus.m0_read = r0; bus.m0_write = w0; bus.m0_address = a0; bus.m0_byteenable = be0; bus.m0_writedata = d0;
        bus.m1_read = r1; bus.m1_write = w1; bus.m1_address = a1; bus.m1_byteenable = be1; bus.m1_writedata = d1;
        #2;
        ob.wr0 = bus.m0_waitrequest;   ob.wr1 = bus.m1_waitrequest;
        ob.v0  = bus.m0_readdatavalid; ob.v1  = bus.m1_readdatavalid;
        ob.d0  = bus.m0_readdata;      ob.d1  = bus.m1_readdata;
        ob.cs  = bus.mem_chipselect;   ob.mw  = bus.mem_write; ob.oor = bus.oor_error;

        q0 = r0 | w0;
        q1 = r1 | w1;
        g0 = reset_n && q0 && (!q1 || lg);
        g1 = reset_n && q1 && !g0;
        ga  = g1 ? a1 : a0;   gbe = g1 ? be1 : be0;  gd = g1 ? d1 : d0;
        gw  = g1 ? w1 : w0;   grd = g1 ? (r1 & ~w1) : (r0 & ~w0);

        ex.wr0 = !g0; ex.wr1 = !g1;
        ex.v0 = pv0;  ex.v1 = pv1;
        ex.d0 = pv0 ? pd : 32'h0;
        ex.d1 = pv1 ? pd : 32'h0;
        ex.cs = g0 | g1;
        ex.mw = (g0 | g1) && gw && (int'(ga) < 5120);
        ex.oor = moor;

        pv0 = 1'b0; pv1 = 1'b0;
        if (!reset_n) model_reset();
        else if (g0 | g1) begin
            lg = g1;
            if (int'(ga) >= 5120) moor = 1'b1;
            if (gw) begin
                if (int'(ga) < 5120) begin
                    word = mmem.exists(int'(ga)) ? mmem[int'(ga)] : 32'h0;
                    for (int b = 0; b < 4; b++) if (gbe[b]) word[8*b +: 8] = gd[8*b +: 8];
                    mmem[int'(ga)] = word;
                end
            end else if (grd) begin
                pv0 = g0; pv1 = g1;
                pd = (int'(ga) < 5120) ? mmem[int'(ga)] : 32'h0;
            end
        end
    endtask

    task automatic c_idle();                                      cycle(0,0,0,0,0, 0,0,0,0,0); endtask
    task automatic c_rd0(input logic [12:0] a);                   cycle(1,0,a,4'hF,0, 0,0,0,0,0); endtask
    task automatic c_rd1(input logic [12:0] a);                   cycle(0,0,0,0,0, 1,0,a,4'hF,0); endtask
    task automatic c_wr0(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d); cycle(0,1,a,be,d, 0,0,0,0,0); endtask
    task automatic c_wr1(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d); cycle(0,0,0,0,0, 0,1,a,be,d); endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        zero_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle(1,0,13'h10,4'hF,0, 0,0,0,0,0);
        tests++;
        if ({ob.wr0, ob.wr1, ob.v0, ob.v1, ob.cs, ob.mw, ob.oor} !== 7'b1100000)
            begin fails++; $display("FAIL reset_flags: got %b want 1100000", {ob.wr0, ob.wr1, ob.v0, ob.v1, ob.cs, ob.mw, ob.oor}); end
        tests++;
        if ({ob.d0, ob.d1} !== 64'h0) begin fails++; $display("FAIL reset_readdata: got %h want 0", {ob.d0, ob.d1}); end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        c_wr0(13'h0010, 4'hF, 32'hCAFEF00D);
        tests++; if (ob.wr0 !== 1'b0) begin fails++; $display("FAIL wr_accept: got %b want 0", ob.wr0); end
        c_rd0(13'h0010);
        tests++; if (ob.wr0 !== 1'b0) begin fails++; $display("FAIL rd_accept: got %b want 0", ob.wr0); end
        c_idle();
        tests++;
        if (ob.v0 !== 1'b1 || ob.d0 !== 32'hCAFEF00D) begin fails++; $display("FAIL rd_return: got v=%b d=%h want v=1 d=cafef00d", ob.v0, ob.d0); end
        tests++;
        if (ob.v1 !== 1'b0 || ob.d1 !== 32'h0) begin fails++; $display("FAIL rd_nonowner: got v=%b d=%h want v=0 d=0", ob.v1, ob.d1); end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 6; i++) c_wr0(13'(32'h20 + i), 4'hF, $urandom);
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1,0,13'(32'h20 + k),4'hF,0, 1,0,13'(32'h25 - k),4'hF,0);
            tests++;
            if ({ob.wr0, ob.wr1} !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {ob.wr0, ob.wr1}, (k % 2 == 0) ? 2'b01 : 2'b10); end
            tests++;
            if (ob !== ex) begin fails++; $display("FAIL rr_model[%0d]: got %h want %h", k, ob, ex); end
        end
        c_idle();
        tests++;
        if (ob.v1 !== 1'b1 || ob.v0 !== 1'b0 || ob !== ex) begin fails++; $display("FAIL rr_tail: got %h want %h", ob, ex); end
    endtask

    task automatic test_byte_enable();
        c_wr1(13'd5, 4'hF, 32'h11223344);
        c_wr1(13'd5, 4'b0010, 32'h0000AB00);
        c_rd1(13'd5);
        c_idle();
        tests++;
        if (ob.v1 !== 1'b1 || ob.d1 !== 32'h1122AB44 || ob.v0 !== 1'b0)
            begin fails++; $display("FAIL byte_lane: got v1=%b d1=%h want v1=1 d1=1122ab44", ob.v1, ob.d1); end
    endtask

    task automatic test_out_of_range();
        c_wr0(13'd0, 4'hF, 32'h0BADBEEF);
        c_wr0(13'd5120, 4'hF, 32'hFFFFFFFF);
        tests++;
        if (ob.mw !== 1'b0 || ob.cs !== 1'b1 || ob.wr0 !== 1'b0)
            begin fails++; $display("FAIL oor_wr: got mw=%b cs=%b wr=%b want 0 1 0", ob.mw, ob.cs, ob.wr0); end
        c_rd0(13'd8191);
        tests++; if (ob.oor !== 1'b1) begin fails++; $display("FAIL oor_set: got %b want 1", ob.oor); end
        c_idle();
        tests++;
        if (ob.v0 !== 1'b1 || ob.d0 !== 32'h0 || ob.oor !== 1'b1)
            begin fails++; $display("FAIL oor_rd: got v=%b d=%h oor=%b want 1 0 1", ob.v0, ob.d0, ob.oor); end
        c_rd0(13'd0);
        c_idle();
        tests++;
        if (ob.v0 !== 1'b1 || ob.d0 !== 32'h0BADBEEF || ob.oor !== 1'b1)
            begin fails++; $display("FAIL oor_addr0: got v=%b d=%h oor=%b want 1 0badbeef 1", ob.v0, ob.d0, ob.oor); end
    endtask

    task automatic test_reset_mid();
        c_rd0(13'h0010);
        @(posedge clk); #1;
        reset_n = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        tests++;
        if (bus.m0_readdatavalid !== 1'b0 || bus.m0_readdata !== 32'h0 || bus.oor_error !== 1'b0)
            begin fails++; $display("FAIL mid_reset: got v=%b d=%h oor=%b want 0 0 0", bus.m0_readdatavalid, bus.m0_readdata, bus.oor_error); end
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1,0,13'd1,4'hF,0, 1,0,13'd2,4'hF,0);
        tests++;
        if ({ob.wr0, ob.wr1} !== 2'b01 || ob !== ex) begin fails++; $display("FAIL post_reset_grant: got %b want 01", {ob.wr0, ob.wr1}); end
    endtask

    function automatic logic [12:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 13'($urandom_range(5120, 8191));
        return 13'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        logic        r[2], w[2];
        logic [12:0] a[2];
        logic [3:0]  be[2];
        logic [31:0] d[2];
        int          op;
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                op = $urandom_range(0, 3);
                a[m] = pick_addr();
                be[m] = 4'($urandom);
                d[m] = $urandom;
                r[m] = (op == 1) || (op == 3);
                w[m] = (op == 2) || (op == 3);
                // Only read words the model knows; partial writes only over known words
                if (int'(a[m]) < 5120 && !mmem.exists(int'(a[m]))) begin
                    if (op != 0) begin r[m] = 1'b0; w[m] = 1'b1; end
                    be[m] = 4'hF;
                end
            end
            cycle(r[0], w[0], a[0], be[0], d[0], r[1], w[1], a[1], be[1], d[1]);
            tests++;
            if (ob !== ex) begin fails++; $display("FAIL random[%0d]: got %h want %h", n, ob, ex); end
        end
        c_idle();
        tests++;
        if (ob !== ex) begin fails++; $display("FAIL random_tail: got %h want %h", ob, ex); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        zero_inputs();
        test_reset();
        test_write_read();
        test_contention();
        test_byte_enable();
        test_out_of_range();
        test_reset_mid();
        pulse_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
